// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine: one 128-bit state per
// handshake, COLS_PER_CYCLE columns transformed per clock.
module mix_columns_seq #(
    parameter int NB             = 128,
    parameter int BYTE           = 8,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NB-1:0] in_data,
    input  logic          in_inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NB-1:0] out_data,
    output logic          busy
);

    if (NB != 128 || BYTE != 8 ||
        !(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_param_check
        $error("mix_columns_seq: unsupported NB/BYTE/COLS_PER_CYCLE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 2/4/8 of every byte are shared by all four output rows.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [31:0] x2, x4, x8, res;
        logic [7:0]  a, b, c, d;
        int          ib, ic, id;
        for (int i = 0; i < 4; i++) begin
            x2[8*i +: 8] = xtime(col[8*i +: 8]);
            x4[8*i +: 8] = xtime(x2[8*i +: 8]);
            x8[8*i +: 8] = xtime(x4[8*i +: 8]);
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            ib = (r + 1) % 4;
            ic = (r + 2) % 4;
            id = (r + 3) % 4;
            if (inv) begin
                a = x8[8*r +: 8] ^ x4[8*r +: 8] ^ x2[8*r +: 8];
                b = x8[8*ib +: 8] ^ x2[8*ib +: 8] ^ col[8*ib +: 8];
                c = x8[8*ic +: 8] ^ x4[8*ic +: 8] ^ col[8*ic +: 8];
                d = x8[8*id +: 8] ^ col[8*id +: 8];
            end else begin
                a = x2[8*r +: 8];
                b = x2[8*ib +: 8] ^ col[8*ib +: 8];
                c = col[8*ic +: 8];
                d = col[8*id +: 8];
            end
            res[8*r +: 8] = a ^ b ^ c ^ d;
        end
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [2:0]    cnt_sum;
    logic [NB-1:0] res_q, res_d;
    logic [NB-1:0] data_q, data_d;
    logic          inv_q, inv_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          accept;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        cnt_sum     = {1'b0, cnt_q} + 3'(COLS_PER_CYCLE);
        in_ready    = (state_q == IDLE) || (state_q == DONE && out_ready);
        accept      = in_valid && in_ready;
        data_d      = accept ? in_data : data_q;
        inv_d       = accept ? in_inv : inv_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    res_d[32*(int'(cnt_q) + k) +: 32] =
                        mix_col(data_q[32*(int'(cnt_q) + k) +: 32], inv_q);
                end
                cnt_d = cnt_sum[1:0];
                if (cnt_sum == 3'd4) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // A block accepted while handing off goes straight back to RUN.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Captured block; no reset needed since it is only read in RUN.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        inv_q  <= inv_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign busy      = busy_q;

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential, parametrised MixColumns / InvMixColumns engine for the AES datapath. It accepts one 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock, so area and throughput can be traded. It returns the transformed state over a second valid/ready handshake. It sits between ShiftRows (InvShiftRows) and AddRoundKey in the iterative round core, and serves both encrypt and decrypt rounds via a per-block mode bit.

## Interface
- NB, 128, state width in bits; only 128 supported.
- BYTE, 8, byte width; only 8 supported.
- COLS_PER_CYCLE, 1, columns processed per RUN cycle; legal values are 1, 2, 4; any other value is an elaboration error.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_inv hold a block.
- in_ready  out  1  engine can accept a block this cycle.
- in_data  in  NB  input state; column c = bits [32c+:32]; row r of column c = bits [32c+8r+:8].
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data.
- out_valid  out  1  out_data holds a finished block.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  NB  transformed state, same byte layout as in_data.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE. Reset values: in_ready=1, out_valid=0, busy=0, out_data=0, column counter=0.
- Accept: when in_valid && in_ready, latch in_data and in_inv, clear the column counter, and go to RUN. Changes on in_data/in_inv after acceptance are ignored.
- RUN: each cycle transform columns [cnt, cnt+COLS_PER_CYCLE) and write them into the result register at the same positions. cnt advances by COLS_PER_CYCLE.
- Leave RUN on the last group (cnt + COLS_PER_CYCLE == 4) and go to DONE.
- Forward transform per column (s0..s3 → s0'..s3'), using the matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] over GF(2^8) with polynomial 0x11B.
- xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0), truncated to 8 bits.
- Inverse transform uses the matrix [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e], built from chained xtime; no lookup tables.
- The mode is fixed per block by the latched in_inv.
- DONE: out_valid=1. out_data is stable while out_valid && !out_ready.
- In DONE, out_valid && out_ready completes the block. Go to RUN if a new block is accepted in the same cycle, otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is combinational from out_ready; no other combinational in→out paths.
- out_data is meaningful only while out_valid=1.
- Reset mid-operation (any state): the in-flight block is discarded, and all outputs take their reset values asynchronously.

## Timing
- Latency: a block accepted at edge E makes out_valid rise at edge E + 4/COLS_PER_CYCLE. That is 4, 2 or 1 cycles.
- Sustained throughput with out_ready=1 and in_valid=1: one block every 4/COLS_PER_CYCLE + 1 cycles. Examples: 5 cycles for C=1, 2 cycles for C=4.
- The DONE→RUN back-to-back handoff costs no idle cycle.
- Backpressure: DONE is held indefinitely with out_ready=0. in_ready stays 0 and no new block is accepted.
- in_valid=0 in DONE with out_ready=1 returns the engine to IDLE; in_ready stays 1.
- Critical path per cycle is COLS_PER_CYCLE parallel column transforms, each at most 3 xtime levels plus an XOR tree.

## Test plan
- Forward, C=1: column 0 bytes (s0..s3) = db 13 53 45; columns 1-3 = f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6; in_inv=0.
  - Required output columns: 8e 4d a1 bc, 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6.
  - out_valid rises exactly 4 edges after acceptance.
- Inverse, C=4: feed the output of the forward test with in_inv=1.
  - Required: the original input state is returned.
  - out_valid rises 1 edge after acceptance.
- Mixed columns, C=2: columns d4 d4 d4 d5 and 2d 26 31 4c (others 00), in_inv=0.
  - Required: d5 d5 d7 d6 and 4d 7e bd f8; zero columns remain 00.
  - Latency is 2 edges.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and a different block presented.
  - Required: out_data stable, in_ready=0, second block not accepted until the out_ready cycle.
  - The second block is then accepted in that same cycle.
- Back-to-back, C=1: 8 random blocks with alternating in_inv, out_ready=1.
  - Required: one result per 5 cycles.
  - Each result matches a software model.
- Reset: assert rst_n=0 mid-RUN (cnt=2), then after release present a new block.
  - Required: immediately out_valid=0, in_ready=1, busy=0, out_data=0.
  - The new block is processed correctly with no residue of the aborted one.
